// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a serialiser with inverted internal line polarity.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise frames are 8N1.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data,
  input  logic                        data_valid,
  output logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        uart_txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            full;
  logic            wr_en;
  logic            pop;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            parity_bit;
`endif

  // Fullness uses the registered count, so a same-cycle pop never makes room.
  assign full       = (count == CW'(FIFO_DEPTH));
  assign wr_en      = data_valid && !full;
  assign bit_end    = (timer == TW'(CLKS_PER_BIT - 1));
  assign ready      = !full;
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= data_valid && full;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Popping straight from STOP into START keeps back-to-back frames gap-free.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (pop) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= mem[rd_ptr];
    end else if (state != IDLE) begin
      timer <= bit_end ? '0 : timer + TW'(1);
      if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   parity_bit <= 1'b0;
    else if (pop) parity_bit <= ^mem[rd_ptr];
  end
`endif

  // Internal polarity: idle/stop 0, start 1, payload bits inverted.
  always_comb begin
    uart_txd = 1'b0;
    case (state)
      START:   uart_txd = 1'b1;
      DATA:    uart_txd = !shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  uart_txd = !parity_bit;
`endif
      default: uart_txd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level waveform model checked every cycle,
// plus a line decoder and literal expectations. Honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       data_valid;
  logic       ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;
  logic       uart_txd;

  int n_checks;
  int n_fail;
  int busy_cycles;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid), .ready(ready),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow), .uart_txd(uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge and are sampled at the next one.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    @(posedge clk);
    #2;
    data_valid = v;
    data       = d;
  endtask

  task automatic waitIdle(input int max_cycles);
    @(posedge clk);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Model: a byte queue and a per-cycle waveform of the frame on the wire.
  logic [7:0] m_q[$];
  bit         m_wave[$];
  bit         m_ovf;
  bit         m_full;

  function automatic void build_frame(input logic [7:0] b);
    for (int k = 0; k < C; k++) m_wave.push_back(1'b1);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < C; k++) m_wave.push_back(!b[i]);
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < C; k++) m_wave.push_back(!(^b));
`endif
    for (int k = 0; k < C; k++) m_wave.push_back(1'b0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_wave.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      if (m_wave.size() > 0) void'(m_wave.pop_front());
      if (m_wave.size() == 0 && m_q.size() > 0) build_frame(m_q.pop_front());
      m_ovf = data_valid && m_full;
      if (data_valid && !m_full) m_q.push_back(data);
    end
  end

  always @(negedge clk) begin
    checkOutput("txd",        {31'd0, uart_txd},   {31'd0, (m_wave.size() > 0) ? m_wave[0] : 1'b0});
    checkOutput("busy",       {31'd0, busy},       {31'd0, m_wave.size() > 0});
    checkOutput("fifo_count", {29'd0, fifo_count}, m_q.size());
    checkOutput("ready",      {31'd0, ready},      {31'd0, m_q.size() < DEPTH});
    checkOutput("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
  end

  always @(negedge clk) if (busy) busy_cycles++;

  // Line decoder: locks on a start bit and samples one cycle into each bit period.
  logic [7:0] rx_bytes[$];
  logic [7:0] dec_byte;
  bit         dec_active;
  int         dec_rel;
  bit         dec_par;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_active = 1'b0;
      dec_rel    = 0;
    end else if (!dec_active) begin
      if (uart_txd) begin
        dec_active = 1'b1;
        dec_rel    = 0;
      end
    end else begin
      dec_rel++;
      if (dec_rel % C == 1 && dec_rel / C >= 1 && dec_rel / C <= 8)
        dec_byte[dec_rel / C - 1] = !uart_txd;
      if (dec_rel == 9 * C + 1) dec_par = uart_txd;
      if (dec_rel == FRAME_BITS * C - 1) begin
        dec_active = 1'b0;
        rx_bytes.push_back(dec_byte);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         exp_line [10];
    logic [7:0] burst [3];
    int         rx_before;

    exp_line = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    burst    = '{8'h00, 8'hFF, 8'h55};
    n_checks = 0;
    n_fail   = 0;
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data       = 8'hA5;

    $display("[TB] reset with data_valid held high");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_txd",   {31'd0, uart_txd},   32'd0);
    checkOutput("rst_busy",  {31'd0, busy},       32'd0);
    checkOutput("rst_ready", {31'd0, ready},      32'd1);
    checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
    data_valid = 1'b0;
    rst_n      = 1'b1;
    applyStimulus(1'b0, 8'h00);

    $display("[TB] single byte 0xA5");
    busy_cycles = 0;
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b0, 8'h00);
    @(posedge clk);
    for (int rel = 0; rel < FRAME_BITS * C; rel++) begin
      @(negedge clk);
      if (rel % C == 1 && rel / C < 9)
        checkOutput("a5_line", {31'd0, uart_txd}, {31'd0, exp_line[rel / C]});
    end
    waitIdle(100);
    checkOutput("a5_busy_cycles", busy_cycles, FRAME_BITS * C);
    checkOutput("a5_decoded", {24'd0, rx_bytes[rx_bytes.size() - 1]}, 32'hA5);

    $display("[TB] burst of three bytes");
    rx_bytes.delete();
    busy_cycles = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, burst[i]);
    applyStimulus(1'b0, 8'h00);
    waitIdle(300);
    checkOutput("burst_busy_cycles", busy_cycles, 3 * FRAME_BITS * C);
    checkOutput("burst_frames", rx_bytes.size(), 32'd3);
    for (int i = 0; i < 3 && i < rx_bytes.size(); i++)
      checkOutput("burst_byte", {24'd0, rx_bytes[i]}, {24'd0, burst[i]});

    $display("[TB] overflow");
    rx_bytes.delete();
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h21);
    applyStimulus(1'b1, 8'h32);
    applyStimulus(1'b1, 8'h43);
    applyStimulus(1'b1, 8'h54);
    applyStimulus(1'b1, 8'h65);
    checkOutput("ovf_ready_full", {31'd0, ready},      32'd0);
    checkOutput("ovf_count_full", {29'd0, fifo_count}, 32'd4);
    applyStimulus(1'b0, 8'h00);
    checkOutput("ovf_pulse", {31'd0, overflow}, 32'd1);
    @(posedge clk);
    #2;
    checkOutput("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    waitIdle(500);
    checkOutput("ovf_frames", rx_bytes.size(), 32'd5);
    if (rx_bytes.size() == 5) begin
      checkOutput("ovf_first", {24'd0, rx_bytes[0]}, 32'h11);
      checkOutput("ovf_last",  {24'd0, rx_bytes[4]}, 32'h54);
    end

    $display("[TB] reset during data bit 3");
    applyStimulus(1'b1, 8'h30);
    applyStimulus(1'b1, 8'h99);
    applyStimulus(1'b0, 8'h00);
    repeat (17) @(posedge clk);
    #2;
    checkOutput("mid_pre_txd", {31'd0, uart_txd}, 32'd1);
    rx_before = rx_bytes.size();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_txd",   {31'd0, uart_txd},   32'd0);
    checkOutput("mid_rst_busy",  {31'd0, busy},       32'd0);
    checkOutput("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    checkOutput("mid_after_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_after_rx",   rx_bytes.size(), rx_before);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity frame 0x07");
    rx_bytes.delete();
    busy_cycles = 0;
    applyStimulus(1'b1, 8'h07);
    applyStimulus(1'b0, 8'h00);
    waitIdle(100);
    checkOutput("par_busy_cycles", busy_cycles, 32'd44);
    checkOutput("par_line",        {31'd0, dec_par}, 32'd0);
    checkOutput("par_byte", (rx_bytes.size() > 0) ? {24'd0, rx_bytes[0]} : 32'hFFFF, 32'h07);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
